// File: rtl/prio_cmp_pkg.sv
// Shared types and constants for the priority-compare arbiter.
package prio_cmp_pkg;
    localparam int PRIO_W = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SCAN  = 2'd1,
        GRANT = 2'd2
    } arb_state_t;
endpackage

// File: rtl/gt2_cmp.sv
// Unsigned 2-bit greater-than comparator shared by the arbiter scan.
module gt2_cmp
    import prio_cmp_pkg::*;
(
    input  logic [PRIO_W-1:0] a,
    input  logic [PRIO_W-1:0] b,
    output logic              f
);
    assign f = (a > b);
endmodule

// File: rtl/prio_cmp_arbiter.sv
// Sequential priority arbiter: snapshot, scan one requester per cycle through
// one gt2_cmp, then hold the winner on a valid/ready port. Option: PRIO_CMP_ARBITER_RR_TIE_EN.
module prio_cmp_arbiter
    import prio_cmp_pkg::*;
#(
    parameter  int N_REQ = 4,
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_REQ-1:0]        req,
    input  logic [2*N_REQ-1:0]      prio,
    output logic                    gnt_valid,
    input  logic                    gnt_ready,
    output logic [IDX_W-1:0]        gnt_idx,
    output logic [N_REQ-1:0]        gnt_onehot,
    output logic [PRIO_W-1:0]       gnt_prio,
    output logic                    busy
);
    arb_state_t                     state;
    logic [N_REQ-1:0]               req_q;
    logic [N_REQ-1:0][PRIO_W-1:0]   prio_q;
    logic [IDX_W-1:0]               ptr;
    logic [IDX_W-1:0]               cnt;
    logic [IDX_W-1:0]               best_idx;
    logic [PRIO_W-1:0]              best_prio;
    logic                           best_vld;
    logic [IDX_W-1:0]               start_idx;
    logic [PRIO_W-1:0]              cur_prio;
    logic                           cur_req;
    logic                           cur_gt;
    logic                           take;

    function automatic logic [IDX_W-1:0] inc_wrap(input logic [IDX_W-1:0] v);
        return (v == IDX_W'(N_REQ - 1)) ? '0 : v + 1'b1;
    endfunction

`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
    logic [IDX_W-1:0] rr_ptr;
    assign start_idx = rr_ptr;
`else
    assign start_idx = '0;
`endif

    assign cur_prio = prio_q[ptr];
    assign cur_req  = req_q[ptr];

    gt2_cmp u_cmp (
        .a (cur_prio),
        .b (best_prio),
        .f (cur_gt)
    );

    // Strict greater-than: on a tie the earlier-scanned index keeps the win.
    assign take = cur_req && (!best_vld || cur_gt);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            req_q      <= '0;
            prio_q     <= '0;
            ptr        <= '0;
            cnt        <= '0;
            best_idx   <= '0;
            best_prio  <= '0;
            best_vld   <= 1'b0;
            gnt_valid  <= 1'b0;
            gnt_idx    <= '0;
            gnt_onehot <= '0;
            gnt_prio   <= '0;
            busy       <= 1'b0;
`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
            rr_ptr     <= '0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        req_q    <= req;
                        prio_q   <= prio;
                        ptr      <= start_idx;
                        cnt      <= '0;
                        best_vld <= 1'b0;
                        busy     <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (take) begin
                        best_idx  <= ptr;
                        best_prio <= cur_prio;
                        best_vld  <= 1'b1;
                    end
                    ptr <= inc_wrap(ptr);
                    cnt <= cnt + 1'b1;
                    if (cnt == IDX_W'(N_REQ - 1))
                        state <= GRANT;
                end
                GRANT: begin
                    // First GRANT cycle copies the settled best_* into the output registers.
                    if (!gnt_valid) begin
                        gnt_valid  <= 1'b1;
                        gnt_idx    <= best_idx;
                        gnt_onehot <= N_REQ'(1) << best_idx;
                        gnt_prio   <= best_prio;
                    end else if (gnt_ready) begin
                        gnt_valid  <= 1'b0;
                        gnt_idx    <= '0;
                        gnt_onehot <= '0;
                        gnt_prio   <= '0;
                        busy       <= 1'b0;
`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
                        rr_ptr     <= inc_wrap(best_idx);
`endif
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_prio_cmp_arbiter.sv
// Self-checking bench for prio_cmp_arbiter: vector table, corner sequences, random vs. model.
module tb_prio_cmp_arbiter;
    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] req = '0;
    logic [7:0] prio = '0;
    logic       gnt_ready = 1'b0;
    logic       gnt_valid;
    logic [1:0] gnt_idx;
    logic [3:0] gnt_onehot;
    logic [1:0] gnt_prio;
    logic       busy;

    logic [1:0] ca, cb;
    logic       cf;

    int passed = 0;
    int total  = 0;
    int rr     = 0;

    always #5 clk = ~clk;

    prio_cmp_arbiter #(.N_REQ(N)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .prio       (prio),
        .gnt_valid  (gnt_valid),
        .gnt_ready  (gnt_ready),
        .gnt_idx    (gnt_idx),
        .gnt_onehot (gnt_onehot),
        .gnt_prio   (gnt_prio),
        .busy       (busy)
    );

    gt2_cmp u_cmp (.a(ca), .b(cb), .f(cf));

    typedef struct {
        logic [3:0] req;
        logic [7:0] prio;
        int         idx;
        int         pr;
    } vec_t;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    endtask

    // Highest priority among active requesters; ties go to the first such index
    // met when walking from start around the ring.
    function automatic int ref_winner(input logic [3:0] r, input logic [7:0] p, input int start);
        int maxp = -1;
        for (int i = 0; i < N; i++)
            if (r[i] && int'(p[2*i +: 2]) > maxp) maxp = int'(p[2*i +: 2]);
        for (int k = 0; k < N; k++) begin
            int i = (start + k) % N;
            if (r[i] && int'(p[2*i +: 2]) == maxp) return i;
        end
        return -1;
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; req = '0; gnt_ready = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        rr = 0;
    endtask

    task automatic grant_one(input logic [3:0] r, input logic [7:0] p, input int hold,
                             input bit scramble, output int got_idx, output int got_prio);
        int start, ei, ep, lat;
        start = 0;
`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
        start = rr;
`endif
        ei = ref_winner(r, p, start);
        ep = int'(p[2*ei +: 2]);
        got_idx = -1; got_prio = -1;
        @(negedge clk);
        req = r; prio = p; gnt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        if (scramble) begin req = 4'($urandom); prio = 8'($urandom); end
        else req = '0;
        lat = 0;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (gnt_valid) break;
            check("scan_outputs_zero", int'({gnt_idx, gnt_onehot, gnt_prio}), 0);
            @(negedge clk);
            if (scramble) begin req = 4'($urandom); prio = 8'($urandom); end
        end
        check("latency", lat, N + 1);
        if (!gnt_valid) return;
        got_idx = int'(gnt_idx); got_prio = int'(gnt_prio);
        check("gnt_idx", int'(gnt_idx), ei);
        check("gnt_prio", int'(gnt_prio), ep);
        check("gnt_onehot", int'(gnt_onehot), 1 << ei);
        check("busy_in_grant", int'(busy), 1);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (scramble) begin req = 4'($urandom); prio = 8'($urandom); end
            @(posedge clk); #1;
            check("hold_stable", int'({gnt_valid, gnt_idx, gnt_onehot, gnt_prio}),
                  int'({1'b1, 2'(ei), 4'(1 << ei), 2'(ep)}));
        end
        @(negedge clk);
        req = '0; gnt_ready = 1'b1;
        @(posedge clk); #1;
        check("post_hs_valid", int'(gnt_valid), 0);
        check("post_hs_busy", int'(busy), 0);
`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
        rr = (ei + 1) % N;
`endif
    endtask

    initial begin
        vec_t tbl[7];
        int   gi, gp;
        int   exp_tie[5];
`ifdef PRIO_CMP_ARBITER_RR_TIE_EN
        exp_tie = '{0, 1, 2, 3, 0};
`else
        exp_tie = '{0, 0, 0, 0, 0};
`endif
        tbl[0] = '{4'b1111, 8'b11_01_10_00, 3, 3};
        tbl[1] = '{4'b0100, 8'b00_00_00_00, 2, 0};
        tbl[2] = '{4'b0001, 8'b11_11_11_11, 0, 3};
        tbl[3] = '{4'b1010, 8'b10_11_10_11, 1, 2};
        tbl[4] = '{4'b1111, 8'b00_11_11_01, 1, 3};
        tbl[5] = '{4'b1000, 8'b01_00_00_00, 3, 1};
        tbl[6] = '{4'b0110, 8'b00_01_00_00, 2, 1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", int'(gnt_valid), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_outputs", int'({gnt_idx, gnt_onehot, gnt_prio}), 0);
        rst_n = 1'b1;

        // Comparator exhaustive
        for (int a = 0; a < 4; a++)
            for (int b = 0; b < 4; b++) begin
                ca = 2'(a); cb = 2'(b);
                #1;
                check("gt2_cmp", int'(cf), int'(a > b));
            end

        // Table vectors, each from a fresh reset so the scan starts at index 0
        foreach (tbl[i]) begin
            do_reset();
            grant_one(tbl[i].req, tbl[i].prio, i % 2, 1'b0, gi, gp);
            check("tbl_idx", gi, tbl[i].idx);
            check("tbl_prio", gp, tbl[i].pr);
        end

        // Tie handling over five grants
        do_reset();
        for (int k = 0; k < 5; k++) begin
            grant_one(4'b1111, 8'b10_10_10_10, 0, 1'b0, gi, gp);
            check("tie_idx", gi, exp_tie[k]);
        end

        // Backpressure with toggling inputs
        do_reset();
        grant_one(4'b1111, 8'b11_01_10_00, 5, 1'b1, gi, gp);
        check("bp_idx", gi, 3);

        // Reset during the second scan cycle
        do_reset();
        grant_one(4'b0010, 8'b00_00_01_00, 0, 1'b0, gi, gp);
        @(negedge clk);
        req = 4'b1111; prio = 8'b10_10_10_10; gnt_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        req = '0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("midscan_rst_valid", int'(gnt_valid), 0);
        check("midscan_rst_busy", int'(busy), 0);
        @(negedge clk);
        rst_n = 1'b1;
        rr = 0;
        grant_one(4'b1111, 8'b10_10_10_10, 0, 1'b0, gi, gp);
        check("after_rst_tie_idx", gi, 0);

        // Random stimulus against the model
        for (int k = 0; k < 40; k++)
            grant_one(4'($urandom_range(1, 15)), 8'($urandom), $urandom_range(0, 3), 1'b1, gi, gp);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
